// File: rtl/clk_div_gate.sv
// Gated clock divider: produces a registered divided test clock clk_out and a stop window
// spanning exactly n_periods*(hi+lo) clk cycles, for a downstream frequency monitor.
module clk_div_gate #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] div_hi,
  input  logic [CNT_W-1:0] div_lo,
  input  logic [WIN_W-1:0] n_periods,
  output logic             clk_out,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [WIN_W-1:0] period_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic [WIN_W-1:0] n_q, n_d;
  logic [WIN_W-1:0] period_cnt_q, period_cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIN_W-1:0] period_inc;
  logic             hi_last;
  logic             lo_last;

  assign period_inc = period_cnt_q + WIN_W'(1);
  // Latched lengths are never zero, so "length-1" cannot underflow.
  assign hi_last    = (phase_q == hi_q - CNT_W'(1));
  assign lo_last    = (phase_q == lo_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    n_d          = n_q;
    period_cnt_d = period_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          hi_d         = (div_hi == '0) ? CNT_W'(1) : div_hi;
          lo_d         = (div_lo == '0) ? CNT_W'(1) : div_lo;
          n_d          = n_periods;
          period_cnt_d = '0;
          phase_d      = '0;
          state_d      = (n_periods == '0) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (hi_last) begin
          phase_d = '0;
          state_d = LOW;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (lo_last) begin
          phase_d      = '0;
          period_cnt_d = period_inc;
          state_d      = (period_inc == n_q) ? DONE : HIGH;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    clk_out_d = (state_d == HIGH);
    stop_d    = (state_d == HIGH) || (state_d == LOW);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      n_q          <= '0;
      period_cnt_q <= '0;
      clk_out_q    <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      n_q          <= n_d;
      period_cnt_q <= period_cnt_d;
      clk_out_q    <= clk_out_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign stop       = stop_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_clk_div_gate.sv
// Scoreboard bench for clk_div_gate: per-cycle expected {clk_out,stop,done,busy,period_cnt}
// is queued when a window is launched and compared on each falling clock edge.
module tb_clk_div_gate;

  localparam int CNT_W = 8;
  localparam int WIN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] div_hi = '0;
  logic [CNT_W-1:0] div_lo = '0;
  logic [WIN_W-1:0] n_periods = '0;
  logic             clk_out;
  logic             stop;
  logic             busy;
  logic             done;
  logic [WIN_W-1:0] period_cnt;

  typedef struct packed {
    logic             clk_out;
    logic             stop;
    logic             done;
    logic             busy;
    logic [WIN_W-1:0] pcnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  exp_t got;
  int   n_checks = 0;
  int   n_pass   = 0;

  clk_div_gate #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .div_hi    (div_hi),
    .div_lo    (div_lo),
    .n_periods (n_periods),
    .clk_out   (clk_out),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  assign got = '{clk_out: clk_out, stop: stop, done: done, busy: busy, pcnt: period_cnt};

  // Expected trace of one window from the first cycle after start is sampled.
  // cut>0: abort is raised during window cycle number cut, so IDLE follows it.
  task automatic push_window(input int hi, input int lo, input int n, input int cut);
    int  h, l, k;
    bit  ab;
    exp_t x;
    h  = (hi == 0) ? 1 : hi;
    l  = (lo == 0) ? 1 : lo;
    k  = 0;
    ab = 1'b0;
    for (int p = 0; p < n && !ab; p++) begin
      for (int c = 0; c < h + l && !ab; c++) begin
        x = '{clk_out: (c < h), stop: 1'b1, done: 1'b0, busy: 1'b1, pcnt: WIN_W'(p)};
        exp_q.push_back(x);
        k++;
        if (cut != 0 && k == cut) ab = 1'b1;
      end
    end
    if (ab) begin
      x = '{clk_out: 1'b0, stop: 1'b0, done: 1'b0, busy: 1'b0, pcnt: WIN_W'((cut - 1) / (h + l))};
      exp_q.push_back(x);
    end else begin
      x = '{clk_out: 1'b0, stop: 1'b0, done: 1'b1, busy: 1'b1, pcnt: WIN_W'(n)};
      exp_q.push_back(x);
      x = '{clk_out: 1'b0, stop: 1'b0, done: 1'b0, busy: 1'b0, pcnt: WIN_W'(n)};
      exp_q.push_back(x);
    end
  endtask

  task automatic launch(input int hi, input int lo, input int n, input int cut);
    div_hi    = CNT_W'(hi);
    div_lo    = CNT_W'(lo);
    n_periods = WIN_W'(n);
    start     = 1'b1;
    push_window(hi, lo, n, cut);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({clk_out, stop, busy, done, period_cnt} !== {4'b0000, WIN_W'(0)})
      $display("FAIL reset_state: got %b %b %b %b %0d, want 0 0 0 0 0", clk_out, stop, busy, done, period_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int windows[2][3] = '{'{2, 2, 3}, '{3, 1, 4}};
    for (int w = 0; w < 2; w++) begin
      launch(windows[w][0], windows[w][1], windows[w][2], 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL basic_w%0d: got %b want %b", w, got, e);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_clamp();
    int windows[3][3] = '{'{0, 0, 2}, '{0, 3, 1}, '{1, 1, 0}};
    for (int w = 0; w < 3; w++) begin
      launch(windows[w][0], windows[w][1], windows[w][2], 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL clamp_w%0d: got %b want %b", w, got, e);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_max_periods();
    launch(3, 2, 15, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL max_periods: got %b want %b", got, e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int idx = 0;
    launch(2, 2, 5, 7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL abort_cyc%0d: got %b want %b", idx, got, e);
      else n_pass++;
      abort = (idx == 6);
      idx++;
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_idle();
    exp_t x;
    start = 1'b1;
    abort = 1'b1;
    x = '{clk_out: 1'b0, stop: 1'b0, done: 1'b0, busy: 1'b0, pcnt: WIN_W'(1)};
    exp_q.push_back(x);
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL abort_idle: got %b want %b", got, e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    div_hi    = CNT_W'(2);
    div_lo    = CNT_W'(1);
    n_periods = WIN_W'(2);
    start     = 1'b1;
    push_window(2, 1, 2, 0);
    push_window(4, 1, 1, 0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL back_to_back_cyc%0d: got %b want %b", idx, got, e);
      else n_pass++;
      if (idx == 1) begin
        div_hi    = CNT_W'(4);
        n_periods = WIN_W'(1);
      end
      if (idx == 10) start = 1'b0;
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_rst_mid();
    launch(1, 1, 4, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL rst_mid_pre%0d: got %b want %b", i, got, e);
      else n_pass++;
      if (i < 2) @(negedge clk);
    end
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({clk_out, stop, busy, done, period_cnt} !== {4'b0000, WIN_W'(0)})
      $display("FAIL rst_async: got %b %b %b %b %0d, want 0 0 0 0 0", clk_out, stop, busy, done, period_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    launch(2, 1, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL rst_restart: got %b want %b", got, e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_max_periods();
    test_abort();
    test_abort_idle();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
